// File: rtl/mips_boot_pkg.sv
// Shared definitions for the mips boot loader: state encoding, default
// memory geometry and a sizing helper for the phase counter.
package mips_boot_pkg;

    localparam int DEF_ADDR_W = 6;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_HOLD = 3'd2,
        ST_RUN  = 3'd3,
        ST_DONE = 3'd4
    } boot_state_e;

    // Bits needed to hold (max(a,b) - 1), never less than one.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/boot_cycle_counter.sv
// Loadable down-counter that flags terminal count; times the HOLD and RUN phases.
module boot_cycle_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             tc
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: load wins, otherwise decrement and stick at zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != {CNT_W{1'b0}})) begin
            count_d = count_q - CNT_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= {CNT_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == {CNT_W{1'b0}});

endmodule

// File: rtl/mips_boot_loader.sv
// Streams a program into instruction memory, then sequences the core's reset:
// hold for RESET_HOLD cycles, run for RUN_CYCLES cycles, then park in DONE.
module mips_boot_loader
    import mips_boot_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int RESET_HOLD = 2,
    parameter int RUN_CYCLES = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              prog_valid,
    input  logic [DATA_W-1:0] prog_data,
    input  logic              prog_last,
    output logic              prog_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              cpu_rst_n,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [ADDR_W:0]   word_count
);

    localparam int                CNT_W   = cnt_width(RESET_HOLD, RUN_CYCLES);
    localparam logic [ADDR_W-1:0] PTR_MAX = {ADDR_W{1'b1}};
    localparam logic [ADDR_W:0]   WC_MAX  = {1'b1, {ADDR_W{1'b0}}};

    boot_state_e       state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   wc_q, wc_d;
    logic              ovf_q, ovf_d;
    logic              done_q, done_d;
    logic              cpu_rst_n_q, cpu_rst_n_d;

    logic              accept_s;
    logic              session_start_s;
    logic              cnt_load_s;
    logic [CNT_W-1:0]  cnt_val_s;
    logic              cnt_en_s;
    logic              cnt_tc_s;

    assign accept_s        = (state_q == ST_LOAD) && prog_valid && !abort;
    assign session_start_s = (state_q != ST_LOAD) && (state_d == ST_LOAD);

    boot_cycle_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load_s),
        .load_val (cnt_val_s),
        .en       (cnt_en_s),
        .tc       (cnt_tc_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides every other input.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = start ? ST_LOAD : ST_IDLE;
                ST_LOAD: begin
                    if (accept_s && (prog_last || (ptr_q == PTR_MAX))) begin
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
                ST_HOLD: state_d = cnt_tc_s ? ST_RUN : ST_HOLD;
                ST_RUN:  state_d = cnt_tc_s ? ST_DONE : ST_RUN;
                ST_DONE: state_d = start ? ST_LOAD : ST_DONE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Output decode and phase-counter control.
    always_comb begin
        prog_ready = (state_q == ST_LOAD) && !abort;
        imem_we    = accept_s;
        imem_addr  = ptr_q;
        imem_wdata = prog_data;
        busy       = (state_q == ST_LOAD) || (state_q == ST_HOLD) || (state_q == ST_RUN);
        cnt_load_s = 1'b0;
        cnt_val_s  = {CNT_W{1'b0}};
        cnt_en_s   = 1'b0;
        if ((state_q != ST_HOLD) && (state_d == ST_HOLD)) begin
            cnt_load_s = 1'b1;
            cnt_val_s  = CNT_W'(RESET_HOLD - 1);
        end else if ((state_q == ST_HOLD) && (state_d == ST_RUN)) begin
            cnt_load_s = 1'b1;
            cnt_val_s  = CNT_W'(RUN_CYCLES - 1);
        end else begin
            cnt_en_s   = (state_q == ST_HOLD) || (state_q == ST_RUN);
        end
    end

    // Session registers; overflow and word_count survive abort for inspection.
    always_comb begin
        ptr_d       = ptr_q;
        wc_d        = wc_q;
        ovf_d       = ovf_q;
        done_d      = (state_d == ST_DONE);
        cpu_rst_n_d = (state_d == ST_RUN);
        if (session_start_s) begin
            ptr_d = {ADDR_W{1'b0}};
            wc_d  = {(ADDR_W+1){1'b0}};
            ovf_d = 1'b0;
        end else if (accept_s) begin
            ptr_d = ptr_q + ADDR_W'(1);
            wc_d  = (wc_q == WC_MAX) ? wc_q : (wc_q + (ADDR_W+1)'(1));
            ovf_d = ovf_q | (!prog_last && (ptr_q == PTR_MAX));
        end else begin
            ptr_d = ptr_q;
            wc_d  = wc_q;
            ovf_d = ovf_q;
        end
    end

    // Datapath and core-reset registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= {ADDR_W{1'b0}};
            wc_q        <= {(ADDR_W+1){1'b0}};
            ovf_q       <= 1'b0;
            done_q      <= 1'b0;
            cpu_rst_n_q <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            wc_q        <= wc_d;
            ovf_q       <= ovf_d;
            done_q      <= done_d;
            cpu_rst_n_q <= cpu_rst_n_d;
        end
    end

    assign cpu_rst_n  = cpu_rst_n_q;
    assign done       = done_q;
    assign overflow   = ovf_q;
    assign word_count = wc_q;

endmodule

// File: tb/tb_mips_boot_loader.sv
// Self-checking bench: table of load/run sessions on a 64-word and a 4-word
// loader, checked against a queue-based model of writes and reset timing.
module tb_mips_boot_loader;

    localparam int RH = 2;
    localparam int RC = 15;

    logic        clk = 1'b0;
    logic        rst_n, sel, start_v, abort_v, valid_v, last_v;
    logic [31:0] data_v;

    logic        b_ready, b_we, b_cpu, b_busy, b_done, b_ovf;
    logic [5:0]  b_addr;
    logic [31:0] b_wdata;
    logic [6:0]  b_wc;
    logic        s_ready, s_we, s_cpu, s_busy, s_done, s_ovf;
    logic [1:0]  s_addr;
    logic [31:0] s_wdata;
    logic [2:0]  s_wc;

    always #5 clk = ~clk;

    mips_boot_loader #(.ADDR_W(6), .DATA_W(32), .RESET_HOLD(RH), .RUN_CYCLES(RC)) dut_big (
        .clk(clk), .rst_n(rst_n), .start(start_v & ~sel), .abort(abort_v & ~sel),
        .prog_valid(valid_v & ~sel), .prog_data(data_v), .prog_last(last_v),
        .prog_ready(b_ready), .imem_we(b_we), .imem_addr(b_addr), .imem_wdata(b_wdata),
        .cpu_rst_n(b_cpu), .busy(b_busy), .done(b_done), .overflow(b_ovf), .word_count(b_wc));

    mips_boot_loader #(.ADDR_W(2), .DATA_W(32), .RESET_HOLD(RH), .RUN_CYCLES(RC)) dut_small (
        .clk(clk), .rst_n(rst_n), .start(start_v & sel), .abort(abort_v & sel),
        .prog_valid(valid_v & sel), .prog_data(data_v), .prog_last(last_v),
        .prog_ready(s_ready), .imem_we(s_we), .imem_addr(s_addr), .imem_wdata(s_wdata),
        .cpu_rst_n(s_cpu), .busy(s_busy), .done(s_done), .overflow(s_ovf), .word_count(s_wc));

    wire        m_ready = sel ? s_ready : b_ready;
    wire        m_we    = sel ? s_we    : b_we;
    wire        m_cpu   = sel ? s_cpu   : b_cpu;
    wire        m_busy  = sel ? s_busy  : b_busy;
    wire        m_done  = sel ? s_done  : b_done;
    wire        m_ovf   = sel ? s_ovf   : b_ovf;
    wire [5:0]  m_addr  = sel ? {4'b0, s_addr} : b_addr;
    wire [31:0] m_wdata = sel ? s_wdata : b_wdata;
    wire [6:0]  m_wc    = sel ? {4'b0, s_wc} : b_wc;

    typedef struct {
        logic [5:0]  addr;
        logic [31:0] data;
        logic        valid;
    } wr_t;

    wr_t  wr_q[$];
    int   cyc = 0;
    int   last_we_cyc = 0;
    int   rise_cyc = 0;
    int   fall_cyc = 0;
    logic prev_cpu = 1'b0;

    // Write/reset-edge recorder, sampling 1 ns after the falling edge.
    always begin
        @(negedge clk);
        #1;
        cyc <= cyc + 1;
        if (m_we) begin
            wr_q.push_back('{addr: m_addr, data: m_wdata, valid: valid_v});
            last_we_cyc <= cyc;
        end
        if (m_cpu && !prev_cpu) rise_cyc <= cyc;
        if (!m_cpu && prev_cpu) fall_cyc <= cyc;
        prev_cpu <= m_cpu;
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit sel;
        int n;
        bit use_last;
        int stall_max;
        int abort_at;
        bit noise;
        bit fixed;
        int exp_count;
        bit exp_ovf;
    } vec_t;

    vec_t        vecs[8];
    logic [31:0] fixed_prog[4];

    task automatic run_session(input vec_t v);
        int          cap;
        int          n_exp;
        int          base;
        int          b;
        bit          pulsed;
        logic [31:0] prog[$];
        cap   = v.sel ? 4 : 64;
        n_exp = (v.n < cap) ? v.n : cap;
        sel   = v.sel;
        for (int i = 0; i < v.n; i++) prog.push_back(v.fixed ? fixed_prog[i % 4] : $urandom);
        base = wr_q.size();
        @(negedge clk); start_v = 1'b1;
        @(negedge clk); start_v = 1'b0;
        check("start_busy", m_busy, 1);
        check("start_clears", {m_done, m_ovf, m_cpu, m_wc}, 0);
        for (int i = 0; i < v.n; i++) begin
            if (i >= cap) begin
                valid_v = 1'b1; data_v = prog[i]; last_v = 1'b0;
                #1;
                check("no_accept_past_cap", {m_ready, m_we}, 0);
                @(negedge clk); valid_v = 1'b0;
                break;
            end
            repeat ($urandom_range(0, v.stall_max)) begin
                data_v = $urandom;
                @(negedge clk);
            end
            if (v.noise && i == 2) begin
                start_v = 1'b1; @(negedge clk); start_v = 1'b0;
            end
            valid_v = 1'b1; data_v = prog[i]; last_v = v.use_last && (i == v.n - 1);
            b = 0;
            while (!m_ready && b < 50) begin @(negedge clk); b++; end
            if (b >= 50) begin
                check("accept_timeout", 0, 1);
                break;
            end
            @(negedge clk);
            valid_v = 1'b0; last_v = 1'b0;
        end
        valid_v = 1'b0;
        if (v.abort_at > 0) begin
            b = 0;
            while (!m_cpu && b < 50) begin @(negedge clk); b++; end
            check("run_entered", m_cpu, 1);
            repeat (v.abort_at - 1) @(negedge clk);
            abort_v = 1'b1; valid_v = 1'b1;
            @(negedge clk);
            abort_v = 1'b0; valid_v = 1'b0;
            check("abort_cpu_rst", m_cpu, 0);
            check("abort_idle", {m_busy, m_done}, 0);
            check("abort_wc_kept", m_wc, v.exp_count);
        end else begin
            b = 0; pulsed = 1'b0;
            while (!m_done && b < 200) begin
                @(negedge clk); b++;
                if (v.noise && m_cpu && !pulsed) begin start_v = 1'b1; pulsed = 1'b1; end
                else start_v = 1'b0;
            end
            start_v = 1'b0;
            @(negedge clk);
            check("done", {m_done, m_busy, m_cpu}, 3'b100);
            check("overflow", m_ovf, v.exp_ovf);
            check("word_count", m_wc, v.exp_count);
            check("hold_len", rise_cyc - last_we_cyc, RH + 1);
            check("run_len", fall_cyc - rise_cyc, RC);
        end
        check("n_writes", wr_q.size() - base, n_exp);
        for (int i = 0; i < n_exp && base + i < wr_q.size(); i++) begin
            check("wr_addr", wr_q[base + i].addr, i);
            check("wr_data", wr_q[base + i].data, prog[i]);
            check("wr_while_valid", wr_q[base + i].valid, 1);
        end
    endtask

    initial begin
        int b;
        int base;
        fixed_prog[0] = 32'h20080005; fixed_prog[1] = 32'h20090003;
        fixed_prog[2] = 32'h01095020; fixed_prog[3] = 32'h00000000;
        //           sel   n  last  stall abort noise fixed cnt ovf
        vecs[0] = '{1'b0, 4, 1'b1, 0, 0, 1'b0, 1'b1, 4, 1'b0};
        vecs[1] = '{1'b0, 4, 1'b1, 3, 0, 1'b0, 1'b0, 4, 1'b0};
        vecs[2] = '{1'b1, 6, 1'b0, 0, 0, 1'b0, 1'b0, 4, 1'b1};
        vecs[3] = '{1'b0, 5, 1'b1, 2, 0, 1'b1, 1'b0, 5, 1'b0};
        vecs[4] = '{1'b0, 3, 1'b1, 1, 7, 1'b0, 1'b0, 3, 1'b0};
        vecs[5] = '{1'b0, 7, 1'b1, 1, 0, 1'b0, 1'b0, 7, 1'b0};
        vecs[6] = '{1'b1, 4, 1'b1, 1, 0, 1'b0, 1'b0, 4, 1'b0};
        vecs[7] = '{1'b0, 1, 1'b1, 0, 0, 1'b0, 1'b0, 1, 1'b0};

        rst_n = 1'b0; sel = 1'b0; start_v = 1'b0; abort_v = 1'b0;
        valid_v = 1'b0; last_v = 1'b0; data_v = 32'd0;
        #12;
        check("reset_big", {b_cpu, b_ready, b_we, b_busy, b_done, b_ovf, b_wc}, 0);
        check("reset_small", {s_cpu, s_ready, s_we, s_busy, s_done, s_ovf, s_wc}, 0);
        @(negedge clk); rst_n = 1'b1;

        for (int k = 0; k < 8; k++) run_session(vecs[k]);

        // Abort in LOAD with a word presented in the same cycle.
        sel = 1'b0;
        base = wr_q.size();
        @(negedge clk); start_v = 1'b1;
        @(negedge clk); start_v = 1'b0;
        valid_v = 1'b1; data_v = 32'hdeadbeef; abort_v = 1'b1;
        #1;
        check("abort_blocks_ready", {m_ready, m_we}, 0);
        @(negedge clk); abort_v = 1'b0; valid_v = 1'b0;
        @(negedge clk);
        check("abort_load_idle", m_busy, 0);
        check("abort_load_nowrite", wr_q.size() - base, 0);

        // Asynchronous reset between edges while the core is running.
        @(negedge clk); start_v = 1'b1;
        @(negedge clk); start_v = 1'b0;
        valid_v = 1'b1; data_v = 32'h11111111; last_v = 1'b0;
        @(negedge clk); data_v = 32'h22222222; last_v = 1'b1;
        @(negedge clk); valid_v = 1'b0; last_v = 1'b0;
        b = 0;
        while (!m_cpu && b < 50) begin @(negedge clk); b++; end
        check("async_run_entered", m_cpu, 1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_cpu", b_cpu, 0);
        check("async_rst_outs", {b_ready, b_we, b_busy, b_done, b_ovf, b_wc}, 0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_idle", {b_ready, b_busy, b_cpu}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
